// File: rtl/id_pkg.sv
// id_pkg: shared types and constants for the decode/issue stage.
//   alu_op_t     : ALU operation requested from EX
//   imm_sel_t    : immediate format selector produced by the decoder
//   issue_ctrl_t : EX/MEM/WB control bundle carried in the ID/EX register
//   ISSUE_NOP    : all-zero control bundle (no side effects)
//   OP_*         : RV32I major opcodes
//   alu_from_f3  : funct3/alt-bit to ALU operation
//   imm_gen      : 32-bit sign-extended immediate for a given format
package id_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10,  // LUI: result is the immediate
        ALU_ADD_PC = 4'd11   // AUIPC/JAL: pc + immediate
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_sel_t;

    // Branches: EX takes the branch when (alu_op==ALU_SUB ? zero : result[0])
    // XOR inv_branch, so BNE/BGE/BGEU reuse the BEQ/BLT/BLTU comparators.
    typedef struct packed {
        alu_op_t    alu_op;
        logic       alu_src_b;   // 1: operand B is the immediate
        logic       branch;
        logic       inv_branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] rw_type;     // load/store funct3 (size, signedness)
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal;
    } issue_ctrl_t;

    localparam issue_ctrl_t ISSUE_NOP = '{
        alu_op:     ALU_ADD,
        alu_src_b:  1'b0,
        branch:     1'b0,
        inv_branch: 1'b0,
        jump:       1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        rw_type:    3'b000,
        mem_to_reg: 1'b0,
        reg_write:  1'b0,
        illegal:    1'b0
    };

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_sel_t sel);
        logic [31:0] imm;
        case (sel)
            IMM_I:   imm = {{20{i[31]}}, i[31:20]};
            IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   imm = {i[31:12], 12'b0};
            IMM_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/id_decoder.sv
// id_decoder: purely combinational RV32I decoder.
//   instr    in  32   instruction word
//   ctrl     out      EX/MEM/WB control bundle (ISSUE_NOP + illegal for unknown encodings)
//   imm_sel  out      immediate format
//   uses_rs1 out  1   instruction reads rs1 (feeds hazard detection)
//   uses_rs2 out  1   instruction reads rs2
module id_decoder
    import id_pkg::*;
(
    input  logic [31:0] instr,
    output issue_ctrl_t ctrl,
    output imm_sel_t    imm_sel,
    output logic        uses_rs1,
    output logic        uses_rs2
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       alt;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign alt    = instr[30];

    always_comb begin
        ctrl     = ISSUE_NOP;
        imm_sel  = IMM_NONE;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_LUI: begin
                ctrl.alu_op    = ALU_PASS_B;
                ctrl.alu_src_b = 1'b1;
                ctrl.reg_write = 1'b1;
                imm_sel        = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.alu_op    = ALU_ADD_PC;
                ctrl.alu_src_b = 1'b1;
                ctrl.reg_write = 1'b1;
                imm_sel        = IMM_U;
            end
            OP_JAL: begin
                ctrl.alu_op    = ALU_ADD_PC;
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                imm_sel        = IMM_J;
            end
            OP_JALR: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src_b = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                imm_sel        = IMM_I;
                uses_rs1       = 1'b1;
            end
            OP_BRANCH: begin
                if (f3[2:1] == 2'b01) begin
                    ctrl.illegal = 1'b1;
                end else begin
                    ctrl.alu_op     = (f3[2] == 1'b0) ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
                    ctrl.branch     = 1'b1;
                    ctrl.inv_branch = f3[0];
                    imm_sel         = IMM_B;
                    uses_rs1        = 1'b1;
                    uses_rs2        = 1'b1;
                end
            end
            OP_LOAD: begin
                ctrl.alu_op     = ALU_ADD;
                ctrl.alu_src_b  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.rw_type    = f3;
                imm_sel         = IMM_I;
                uses_rs1        = 1'b1;
            end
            OP_STORE: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src_b = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.rw_type   = f3;
                imm_sel        = IMM_S;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OP_IMM: begin
                // bit 30 only selects SRAI; for ADDI it is part of the immediate
                ctrl.alu_op    = alu_from_f3(f3, (f3 == 3'b101) && alt);
                ctrl.alu_src_b = 1'b1;
                ctrl.reg_write = 1'b1;
                imm_sel        = IMM_I;
                uses_rs1       = 1'b1;
            end
            OP_REG: begin
                ctrl.alu_op    = alu_from_f3(f3, alt);
                ctrl.reg_write = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_issue_stage.sv
// id_issue_stage: decode/issue stage between the IF/ID register and EX.
// Decodes the instruction, reads the register file, builds the immediate and
// holds the result in the ID/EX register. Inserts a bubble on load-use hazards
// and honours the EX branch/jump flush.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready          upstream handshake; in_pc, in_instr
//   flush                      kill stage contents (priority over all but reset)
//   wb_we/wb_addr/wb_data      register file write port
//   out_valid/out_ready        downstream handshake; out_pc, out_rs1_data,
//                              out_rs2_data, out_imm, out_rd, out_ctrl
//   stall_cnt                  saturating count of load-use bubble cycles
//
// Configuration macro ID_BYPASS_EN: when defined, a same-cycle writeback to a
// source register is forwarded into the read; otherwise the instruction waits
// one cycle (wb_haz) and reads the freshly written value.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid must not depend on ready, and the producer holds its payload
// stable while valid is high and ready is low.
module id_issue_stage
    import id_pkg::*;
#(
    parameter  int XLEN    = 32,
    parameter  int NREGS   = 32,
    localparam int RADDR_W = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [31:0]        in_instr,
    input  logic               flush,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]    wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_rs1_data,
    output logic [XLEN-1:0]    out_rs2_data,
    output logic [XLEN-1:0]    out_imm,
    output logic [RADDR_W-1:0] out_rd,
    output issue_ctrl_t        out_ctrl,
    output logic [31:0]        stall_cnt
);

    // Register numbers at or above NREGS read as 0 and ignore writes.
    localparam logic [RADDR_W:0] NREGS_W = (RADDR_W + 1)'(NREGS);

    issue_ctrl_t        dec_ctrl;
    imm_sel_t           imm_sel;
    logic               uses_rs1;
    logic               uses_rs2;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic [RADDR_W-1:0] rd;
    logic               rs1_ok;
    logic               rs2_ok;
    logic               wb_ok;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic               advance;
    logic               hazard;
    logic               wb_haz;
    logic               fire;
    logic [XLEN-1:0]    regs [NREGS];

    id_decoder u_decoder (
        .instr    (in_instr),
        .ctrl     (dec_ctrl),
        .imm_sel  (imm_sel),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    // Register fields are taken at RADDR_W bits (NREGS <= 32 assumed).
    assign rs1 = in_instr[15 +: RADDR_W];
    assign rs2 = in_instr[20 +: RADDR_W];
    assign rd  = in_instr[7 +: RADDR_W];

    assign rs1_ok = (rs1 != '0) && ({1'b0, rs1} < NREGS_W);
    assign rs2_ok = (rs2 != '0) && ({1'b0, rs2} < NREGS_W);
    assign wb_ok  = wb_we && (wb_addr != '0) && ({1'b0, wb_addr} < NREGS_W);

    assign imm = XLEN'($signed(imm_gen(in_instr, imm_sel)));

    // Register file: combinational read, x0 and out-of-range read as zero.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_ok) rs1_data = regs[rs1];
        if (rs2_ok) rs2_data = regs[rs2];
`ifdef ID_BYPASS_EN
        if (rs1_ok && wb_ok && (wb_addr == rs1)) rs1_data = wb_data;
        if (rs2_ok && wb_ok && (wb_addr == rs2)) rs2_data = wb_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_ok) begin
            regs[wb_addr] <= wb_data;
        end
    end

`ifdef ID_BYPASS_EN
    assign wb_haz = 1'b0;
`else
    // Without forwarding the read would see the stale value: wait one cycle.
    assign wb_haz = wb_ok && ((uses_rs1 && (wb_addr == rs1)) ||
                              (uses_rs2 && (wb_addr == rs2)));
`endif

    assign advance  = !out_valid || out_ready;
    assign hazard   = out_valid && out_ctrl.mem_read && (out_rd != '0) &&
                      ((uses_rs1 && (out_rd == rs1)) || (uses_rs2 && (out_rd == rs2)));
    assign in_ready = advance && !hazard && !flush && !wb_haz;
    assign fire     = in_valid && in_ready;

    // ID/EX register. On a bubble only out_valid drops; payload keeps its value.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_imm      <= '0;
            out_rd       <= '0;
            out_ctrl     <= ISSUE_NOP;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance) begin
            out_valid <= fire;
            if (fire) begin
                out_pc       <= in_pc;
                out_rs1_data <= rs1_data;
                out_rs2_data <= rs2_data;
                out_imm      <= imm;
                // Non-writing instructions carry rd=0 so they never look like a producer.
                out_rd       <= dec_ctrl.reg_write ? rd : '0;
                out_ctrl     <= dec_ctrl;
            end
        end
    end

    // Counts only load-use bubbles, not writeback holds or flushed cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (in_valid && hazard && advance && !flush && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_id_issue_stage.sv
module tb_id_issue_stage;
  import id_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_rs1_data;
  logic [31:0] out_rs2_data;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  issue_ctrl_t out_ctrl;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  id_issue_stage dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_instr     (in_instr),
    .flush        (flush),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_imm      (out_imm),
    .out_rd       (out_rd),
    .out_ctrl     (out_ctrl),
    .stall_cnt    (stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // instruction encoders
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2v,
                                        input logic [4:0] rs1v, input logic [2:0] f3,
                                        input logic [4:0] rdv, input logic [6:0] op);
    return {f7, rs2v, rs1v, f3, rdv, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1v,
                                        input logic [2:0] f3, input logic [4:0] rdv,
                                        input logic [6:0] op);
    return {im, rs1v, f3, rdv, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] rs2v,
                                        input logic [4:0] rs1v, input logic [2:0] f3,
                                        input logic [6:0] op);
    return {im[11:5], rs2v, rs1v, f3, im[4:0], op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] rs2v,
                                        input logic [4:0] rs1v, input logic [2:0] f3,
                                        input logic [6:0] op);
    return {im[12], im[10:5], rs2v, rs1v, f3, im[4:1], im[11], op};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] im, input logic [4:0] rdv,
                                        input logic [6:0] op);
    return {im, rdv, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] rdv,
                                        input logic [6:0] op);
    return {im[20], im[10:1], im[11], im[19:12], rdv, op};
  endfunction

  // checker
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_instr = 32'h0000_0013;
    in_pc    = 32'h0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_we   = 1'b1;
    wb_addr = a;
    wb_data = d;
    tick();
    wb_we   = 1'b0;
  endtask

  function automatic logic [6:0] flags_of(input issue_ctrl_t c);
    return {c.mem_read, c.mem_write, c.reg_write, c.branch, c.jump, c.illegal, c.alu_src_b};
  endfunction

  // decode vector table; flags = {mem_read, mem_write, reg_write, branch, jump, illegal, alu_src_b}
  typedef struct {
    logic [31:0] instr;
    logic        chk_rs1;
    logic        chk_rs2;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  flags;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [31:0] instr, input logic c1, input logic c2,
                              input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] im, input logic [4:0] rdv,
                              input logic [6:0] fl);
    vec_t v;
    v.instr = instr; v.chk_rs1 = c1; v.chk_rs2 = c2;
    v.rs1 = r1; v.rs2 = r2; v.imm = im; v.rd = rdv; v.flags = fl;
    return v;
  endfunction

  initial begin
    // register contents preloaded below: x1=0x11 x2=0x22 x3=0xFFFFFF00 x4=4
    vecs[0]  = mk(enc_i(12'd5, 5'd1, 3'd0, 5'd2, 7'h13),           1, 0, 32'h11, 0, 32'h5, 5'd2, 7'b0010001);
    vecs[1]  = mk(enc_i(12'hFFF, 5'd2, 3'd0, 5'd6, 7'h13),         1, 0, 32'h22, 0, 32'hFFFF_FFFF, 5'd6, 7'b0010001);
    vecs[2]  = mk(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd7, 7'h33),     1, 1, 32'h11, 32'h22, 32'h0, 5'd7, 7'b0010000);
    vecs[3]  = mk(enc_r(7'h20, 5'd3, 5'd4, 3'd0, 5'd7, 7'h33),     1, 1, 32'h4, 32'hFFFF_FF00, 32'h0, 5'd7, 7'b0010000);
    vecs[4]  = mk(enc_i(12'hFFC, 5'd3, 3'd2, 5'd8, 7'h03),         1, 0, 32'hFFFF_FF00, 0, 32'hFFFF_FFFC, 5'd8, 7'b1010001);
    vecs[5]  = mk(enc_s(12'd8, 5'd2, 5'd1, 3'd2, 7'h23),           1, 1, 32'h11, 32'h22, 32'h8, 5'd0, 7'b0100001);
    vecs[6]  = mk(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0, 7'h63),        1, 1, 32'h11, 32'h22, 32'hFFFF_FFF8, 5'd0, 7'b0001000);
    vecs[7]  = mk(enc_u(20'h12345, 5'd9, 7'h37),                   0, 0, 0, 0, 32'h1234_5000, 5'd9, 7'b0010001);
    vecs[8]  = mk(enc_j(21'h1FFFF0, 5'd1, 7'h6F),                  0, 0, 0, 0, 32'hFFFF_FFF0, 5'd1, 7'b0010100);
    vecs[9]  = mk(32'h0000_007F,                                   0, 0, 0, 0, 32'h0, 5'd0, 7'b0000010);
    vecs[10] = mk(enc_u(20'hFFFFF, 5'd10, 7'h17),                  0, 0, 0, 0, 32'hFFFF_F000, 5'd10, 7'b0010001);
    vecs[11] = mk(enc_i(12'd12, 5'd4, 3'd0, 5'd11, 7'h67),         1, 0, 32'h4, 0, 32'hC, 5'd11, 7'b0010101);

    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    idle();

    // 1. reset
    repeat (3) tick();
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_stall_cnt", {32'b0, stall_cnt}, 64'd0);
    chk("rst_out_ctrl", {{(64 - $bits(issue_ctrl_t)){1'b0}}, out_ctrl}, 64'd0);
    chk("rst_out_pc", {32'b0, out_pc}, 64'd0);
    chk("rst_out_rd", {59'b0, out_rd}, 64'd0);
    reset = 1'b0;
    drive(enc_r(7'h00, 5'd5, 5'd5, 3'd0, 5'd12, 7'h33), 32'h80);
    #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    tick();
    idle();
    chk("rst_x5_valid", {63'b0, out_valid}, 64'd1);
    chk("rst_x5_rs1", {32'b0, out_rs1_data}, 64'd0);
    chk("rst_x5_rs2", {32'b0, out_rs2_data}, 64'd0);
    tick();

    // preload
    wb_write(5'd1, 32'h11);
    wb_write(5'd2, 32'h22);
    wb_write(5'd3, 32'hFFFF_FF00);
    wb_write(5'd4, 32'h4);

    // 2. table-driven decode, back-to-back
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].instr, 32'h1000 + 32'(i) * 4);
      #1;
      chk($sformatf("v%0d_in_ready", i), {63'b0, in_ready}, 64'd1);
      tick();
      chk($sformatf("v%0d_valid", i), {63'b0, out_valid}, 64'd1);
      chk($sformatf("v%0d_pc", i), {32'b0, out_pc}, {32'b0, 32'h1000 + 32'(i) * 4});
      chk($sformatf("v%0d_imm", i), {32'b0, out_imm}, {32'b0, vecs[i].imm});
      chk($sformatf("v%0d_rd", i), {59'b0, out_rd}, {59'b0, vecs[i].rd});
      chk($sformatf("v%0d_flags", i), {57'b0, flags_of(out_ctrl)}, {57'b0, vecs[i].flags});
      if (vecs[i].chk_rs1) chk($sformatf("v%0d_rs1", i), {32'b0, out_rs1_data}, {32'b0, vecs[i].rs1});
      if (vecs[i].chk_rs2) chk($sformatf("v%0d_rs2", i), {32'b0, out_rs2_data}, {32'b0, vecs[i].rs2});
    end
    idle();
    tick();
    chk("tbl_drain_valid", {63'b0, out_valid}, 64'd0);

    // 3. load-use: lw x3,0(x1) ; add x4,x3,x3
    drive(enc_i(12'd0, 5'd1, 3'd2, 5'd3, 7'h03), 32'h1800);
    tick();
    drive(enc_r(7'h00, 5'd3, 5'd3, 3'd0, 5'd4, 7'h33), 32'h1804);
    #1;
    chk("lu_hold_ready", {63'b0, in_ready}, 64'd0);
    tick();
    chk("lu_bubble_valid", {63'b0, out_valid}, 64'd0);
    chk("lu_stall_cnt", {32'b0, stall_cnt}, 64'd1);
    chk("lu_release_ready", {63'b0, in_ready}, 64'd1);
    tick();
    idle();
    chk("lu_add_valid", {63'b0, out_valid}, 64'd1);
    chk("lu_add_pc", {32'b0, out_pc}, 64'h1804);
    chk("lu_add_rs1", {32'b0, out_rs1_data}, 64'hFFFF_FF00);
    chk("lu_stall_cnt2", {32'b0, stall_cnt}, 64'd1);
    tick();

    // 4. EX backpressure
    drive(enc_i(12'd1, 5'd1, 3'd0, 5'd13, 7'h13), 32'h2000);
    tick();
    out_ready = 1'b0;
    drive(enc_i(12'd2, 5'd1, 3'd0, 5'd14, 7'h13), 32'h2004);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", c), {63'b0, in_ready}, 64'd0);
      tick();
      chk($sformatf("bp%0d_valid", c), {63'b0, out_valid}, 64'd1);
      chk($sformatf("bp%0d_pc", c), {32'b0, out_pc}, 64'h2000);
      chk($sformatf("bp%0d_imm", c), {32'b0, out_imm}, 64'h1);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(enc_i(12'(k + 2), 5'd1, 3'd0, 5'(14 + k), 7'h13), 32'h2004 + 32'(k) * 4);
      #1;
      chk($sformatf("rel%0d_in_ready", k), {63'b0, in_ready}, 64'd1);
      exp_q.push_back(32'h2004 + 32'(k) * 4);
      tick();
      chk($sformatf("rel%0d_valid", k), {63'b0, out_valid}, 64'd1);
      chk($sformatf("rel%0d_pc", k), {32'b0, out_pc}, {32'b0, exp_q.pop_front()});
    end
    idle();
    tick();
    chk("bp_stall_cnt", {32'b0, stall_cnt}, 64'd1);

    // 5. flush
    drive(enc_i(12'd3, 5'd1, 3'd0, 5'd17, 7'h13), 32'h3000);
    tick();
    drive(enc_i(12'd4, 5'd1, 3'd0, 5'd18, 7'h13), 32'h3004);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", {63'b0, in_ready}, 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_out_valid", {63'b0, out_valid}, 64'd0);
    chk("fl_retry_ready", {63'b0, in_ready}, 64'd1);
    tick();
    chk("fl_retry_pc", {32'b0, out_pc}, 64'h3004);
    chk("fl_retry_rd", {59'b0, out_rd}, 64'd18);
    drive(enc_i(12'd0, 5'd1, 3'd2, 5'd3, 7'h03), 32'h3008);
    tick();
    drive(enc_r(7'h00, 5'd3, 5'd3, 3'd0, 5'd4, 7'h33), 32'h300C);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk("fl_haz_valid", {63'b0, out_valid}, 64'd0);
    chk("fl_haz_stall_cnt", {32'b0, stall_cnt}, 64'd1);
    tick();

    // 6. writeback during decode: add x8,x7,x0 with x7 <- 0xABCD
    drive(enc_r(7'h00, 5'd0, 5'd7, 3'd0, 5'd8, 7'h33), 32'h4000);
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hABCD;
    #1;
`ifdef ID_BYPASS_EN
    chk("wb_bypass_ready", {63'b0, in_ready}, 64'd1);
    tick();
    wb_we = 1'b0;
`else
    chk("wb_hold_ready", {63'b0, in_ready}, 64'd0);
    tick();
    wb_we = 1'b0;
    #1;
    chk("wb_hold_valid", {63'b0, out_valid}, 64'd0);
    chk("wb_hold_release", {63'b0, in_ready}, 64'd1);
    tick();
`endif
    chk("wb_add_valid", {63'b0, out_valid}, 64'd1);
    chk("wb_add_pc", {32'b0, out_pc}, 64'h4000);
    chk("wb_add_rs1", {32'b0, out_rs1_data}, 64'hABCD);
    chk("wb_add_rs2", {32'b0, out_rs2_data}, 64'd0);
    chk("wb_stall_cnt", {32'b0, stall_cnt}, 64'd1);

    // write to x0 is dropped and never holds the stage
    drive(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd9, 7'h33), 32'h4004);
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h55;
    #1;
    chk("x0_in_ready", {63'b0, in_ready}, 64'd1);
    tick();
    wb_we = 1'b0;
    chk("x0_rs1_same", {32'b0, out_rs1_data}, 64'd0);
    drive(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd9, 7'h33), 32'h4008);
    tick();
    idle();
    chk("x0_rs1_after", {32'b0, out_rs1_data}, 64'd0);
    chk("x0_rs2_after", {32'b0, out_rs2_data}, 64'd0);
    chk("x0_pc_after", {32'b0, out_pc}, 64'h4008);
    tick();
    chk("end_valid", {63'b0, out_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
